// File: rtl/mem_port_arbiter_if.sv
// CPU-side fetch/data ports and memory-side port of the unified-memory arbiter.
// The slave modport is the arbiter view; master is the CPU/memory view.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  logic        bus_err;
  logic        owner;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata,
           bus_err, owner
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata,
           bus_err, owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported memory between instruction fetch and load/store,
// with data priority, fetch anti-starvation and a memory timeout.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 16
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 32;
  localparam int unsigned SW  = 4;
  localparam int unsigned TW  = 8;
  localparam int unsigned TW1 = TW + 1;
  localparam logic [DW-1:0] ERR_DATA   = DW'(32'hDEAD_BEEF);
  localparam logic [SW-1:0] STARVE_MAX = '1;

  typedef enum logic [1:0] {IDLE, ACC_IF, ACC_D, RESP} state_t;

  state_t          state_q, state_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            if_ack_q, if_ack_d;
  logic            d_ack_q, d_ack_d;
  logic            bus_err_q, bus_err_d;
  logic            owner_q, owner_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [TW-1:0]   tmo_q, tmo_d;

  logic            grant_d_c;
  logic            grant_if_c;
  logic            tmo_done_c;

  // IDLE arbitration: data first unless fetch has been starved long enough
  always_comb begin
    grant_d_c  = 1'b0;
    grant_if_c = 1'b0;
    if (state_q == IDLE) begin
      if (bus.d_req && (starve_q < SW'(STARVE_LIMIT))) begin
        grant_d_c = 1'b1;
      end else if (bus.if_req) begin
        grant_if_c = 1'b1;
      end else if (bus.d_req) begin
        grant_d_c = 1'b1;
      end
    end
  end

  // This cycle without mem_ack would be the TIMEOUT-th one
  assign tmo_done_c = ((TW1'(tmo_q) + TW1'(1)) == TW1'(TIMEOUT));

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    tmo_d       = tmo_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    bus_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!bus.if_req) begin
          starve_d = '0;
        end
        if (grant_d_c) begin
          state_d     = ACC_D;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          owner_d     = 1'b1;
          tmo_d       = '0;
          if (bus.if_req && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
          end
        end else if (grant_if_c) begin
          state_d    = ACC_IF;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = bus.if_addr;
          owner_d    = 1'b0;
          tmo_d      = '0;
          starve_d   = '0;
        end
      end

      ACC_IF, ACC_D: begin
        if (!bus.mem_ack) begin
          tmo_d = tmo_q + TW'(1);
        end
        if (bus.mem_ack || tmo_done_c) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          bus_err_d = !bus.mem_ack;
          if (state_q == ACC_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus.mem_ack ? bus.mem_rdata : ERR_DATA;
          end else begin
            d_ack_d = 1'b1;
            // a completed store leaves the load data register untouched
            if (!bus.mem_ack) begin
              d_rdata_d = ERR_DATA;
            end else if (!mem_we_q) begin
              d_rdata_d = bus.mem_rdata;
            end
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      bus_err_q   <= 1'b0;
      owner_q     <= 1'b0;
      starve_q    <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      bus_err_q   <= bus_err_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      tmo_q       <= tmo_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.bus_err   = bus_err_q;
  assign bus.owner     = owner_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the pipelined CPU's instruction-fetch stage (IF port) and its load/store MEM stage (D port).
- Sequences each access as a request/acknowledge transaction against a variable-latency memory.
- Data accesses have fixed priority, bounded by a fetch anti-starvation counter and a memory timeout.
- Sits between the CPU core (PC_out / Addr_out / Data_out / mem_w side) and the data/instruction memory model.

Parameters:
- STARVE_LIMIT, 4, number of consecutive D grants allowed while if_req is waiting before IF is forced to win (legal range 1..15).
- TIMEOUT, 16, cycles in ACC without mem_ack before the transaction is aborted with an error (legal range 2..255).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  32  fetch address.
- if_rdata  out  32  fetched instruction; valid in the if_ack cycle.
- if_ack  out  1  one-cycle completion pulse to IF.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_rdata  out  32  load data; valid in the d_ack cycle.
- d_ack  out  1  one-cycle completion pulse to D.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; valid when mem_ack = 1.
- mem_ack  in  1  memory completion; may assert in the same cycle mem_req first rises.
- bus_err  out  1  pulses with if_ack/d_ack when the transaction timed out.
- owner  out  1  0 = IF, 1 = D; owner of the current or last transaction.

Behaviour:
- States: IDLE, ACC_IF, ACC_D, RESP.
- Reset (reset == 0 at a clock edge): state = IDLE; mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0; if_ack = 0, d_ack = 0, bus_err = 0; if_rdata = 0, d_rdata = 0; owner = 0; starve_cnt = 0, timeout counter = 0.
- Reset mid-transaction: no ack is ever issued for the aborted transaction, and mem_req is low in the next cycle.
- All outputs are registered.
- IDLE arbitration, in priority order:
  - d_req && starve_cnt < STARVE_LIMIT → ACC_D.
  - if_req → ACC_IF.
  - d_req → ACC_D. This covers starve_cnt at limit with if_req low.
  - Otherwise stay in IDLE.
- On the grant edge: latch address, we and wdata from the granted port into mem_* (mem_we = 0 for IF), set owner, set mem_req = 1.
- While in ACC: mem_* hold stable until mem_ack is sampled high.
- starve_cnt rules:
  - +1 (saturating at 15) on each D grant made while if_req = 1.
  - Cleared on an IF grant.
  - Cleared in IDLE whenever if_req = 0.
- ACC_x with mem_ack = 1 at an edge:
  - mem_req ← 0.
  - x_rdata ← mem_rdata (loads and fetches only; d_rdata unchanged on a store).
  - x_ack ← 1, bus_err ← 0.
  - → RESP.
- ACC_x with mem_ack = 0:
  - Timeout counter +1.
  - When it reaches TIMEOUT: mem_req ← 0, x_ack ← 1, bus_err ← 1, x_rdata ← 32'hDEAD_BEEF, → RESP.
- RESP:
  - Ack and bus_err are high for exactly this one cycle, then clear.
  - → IDLE.
  - A requester may keep req high through RESP to mean its next request; it is re-arbitrated in IDLE.
- Timeout counter is cleared on every grant.
- Minimum turnaround:
  - Request sampled in IDLE at edge N → mem_req high after N.
  - Zero-wait memory acks at edge N+1 → x_ack high after N+1.
  - Back to IDLE after N+2.
  - Throughput: one transaction per 3 cycles.
- Requester dropping req during ACC: the transaction still completes and the ack still pulses.
- Changing address/data during ACC has no effect, because the values are latched.
- Simultaneous if_req and d_req in IDLE are resolved by the priority rules above; the loser simply waits with req held.
- mem_ack outside ACC is ignored.

Test Plan:
- Single fetch, zero-wait: reset released, if_req = 1, if_addr = 0x0000_0010, mem_ack tied high with mem_rdata = 0x0010_0093 → mem_req high for exactly 1 cycle with mem_addr = 0x10, mem_we = 0; if_ack pulses 2 cycles after the request was sampled with if_rdata = 0x0010_0093; owner = 0.
- Store with wait states: d_req = 1, d_we = 1, d_addr = 0x100, d_wdata = 0xCAFE_F00D, mem_ack after 3 cycles → mem_addr/mem_wdata/mem_we stable for all 3 cycles; d_ack pulses once; d_rdata unchanged.
- Contention and anti-starvation: d_req and if_req both held continuously, STARVE_LIMIT = 4, zero-wait memory → grant order D, D, D, D, IF, D, D, D, D, IF…; no ack is ever lost.
- Timeout: d_req load, mem_ack held 0, TIMEOUT = 16 → after 16 ACC cycles mem_req drops; d_ack = bus_err = 1 for one cycle; d_rdata = 0xDEAD_BEEF; next request proceeds normally.
- Reset mid-access: assert reset = 0 during ACC_D with mem_ack = 0 → next cycle mem_req = 0, all acks 0, state IDLE; after release, a pending if_req is granted normally.
- Stray mem_ack: pulse mem_ack while IDLE with no requests → no ack outputs and no state change.
